// File: rtl/btn_cond.sv
// btn_cond: per-button sync + debounce + press detect, then a one-deep event slot
// under valid/ack. Define BTN_REPEAT_EN to compile in hold-to-repeat presses.

module btn_cond_lane #(
   parameter logic [15:0] DB_CYCLES = 16'd20000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic lvl,
   output logic press
);
   logic [1:0]  sync_ff;
   logic [15:0] db_cnt;
   logic        lvl_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_ff <= '0;
         db_cnt  <= '0;
         lvl     <= 1'b0;
         lvl_d   <= 1'b0;
      end else begin
         sync_ff <= {sync_ff[0], raw};
         lvl_d   <= lvl;
         if (sync_ff[1] == lvl) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_CYCLES - 16'd1) begin
            lvl    <= sync_ff[1];
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 16'd1;
         end
      end
   end

   assign press = lvl & ~lvl_d;
endmodule

module btn_cond #(
   parameter int          N_BTN      = 5,
   parameter logic [15:0] DB_CYCLES  = 16'd20000,
   parameter logic [19:0] REP_DELAY  = 20'd250000,
   parameter logic [19:0] REP_PERIOD = 20'd60000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_lvl,
   output logic [N_BTN-1:0] evt_code,
   output logic             evt_valid,
   input  logic             evt_ack,
   output logic             evt_ovf
);
   logic [N_BTN-1:0] press, win, press_code;
   logic             real_any, multi, press_vld, slot_free, accept, drop;

   for (genvar i = 0; i < N_BTN; i++) begin : g_lane
      btn_cond_lane #(.DB_CYCLES(DB_CYCLES)) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .raw   (btn_raw[i]),
         .lvl   (btn_lvl[i]),
         .press (press[i])
      );
   end

   // Lowest set bit wins; any other simultaneous press is a drop.
   assign win      = press & (~press + N_BTN'(1));
   assign real_any = |press;
   assign multi    = |(press & ~win);

`ifdef BTN_REPEAT_EN
   localparam int IW = (N_BTN > 1) ? $clog2(N_BTN) : 1;

   typedef enum logic [1:0] {IDLE, WAIT1, REPT} rep_st_t;
   rep_st_t        rep_st, rep_st_nxt;
   logic [19:0]    rep_cnt, rep_cnt_nxt, rep_lim;
   logic [IW-1:0]  rep_idx, rep_idx_nxt, win_idx;
   logic           syn_q, syn_set, rep_held, syn_eff;

   always_comb begin
      win_idx = '0;
      for (int i = N_BTN - 1; i >= 0; i--)
         if (press[i]) win_idx = IW'(i);
   end

   assign rep_held = btn_lvl[rep_idx];
   assign rep_lim  = (rep_st == WAIT1) ? REP_DELAY : REP_PERIOD;

   always_comb begin
      rep_st_nxt  = rep_st;
      rep_cnt_nxt = rep_cnt;
      rep_idx_nxt = rep_idx;
      syn_set     = 1'b0;
      if (real_any) begin
         rep_st_nxt  = WAIT1;
         rep_cnt_nxt = '0;
         rep_idx_nxt = win_idx;
      end else if (rep_st != IDLE) begin
         if (!rep_held) begin
            rep_st_nxt  = IDLE;
            rep_cnt_nxt = '0;
         end else if (rep_cnt == rep_lim - 20'd1) begin
            rep_st_nxt  = REPT;
            rep_cnt_nxt = '0;
            syn_set     = 1'b1;
         end else begin
            rep_cnt_nxt = rep_cnt + 20'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_st  <= IDLE;
         rep_cnt <= '0;
         rep_idx <= '0;
         syn_q   <= 1'b0;
      end else begin
         rep_st  <= rep_st_nxt;
         rep_cnt <= rep_cnt_nxt;
         rep_idx <= rep_idx_nxt;
         syn_q   <= syn_set;
      end
   end

   // Registered synthetic press lands one cycle after the count match; a real
   // press or a release in that cycle cancels it.
   assign syn_eff    = syn_q & ~real_any & rep_held;
   assign press_code = real_any ? win : (N_BTN'(1) << rep_idx);
   assign press_vld  = real_any | syn_eff;
`else
   assign press_code = win;
   assign press_vld  = real_any;
`endif

   assign slot_free = !evt_valid || evt_ack;
   assign accept    = evt_valid && evt_ack;
   assign drop      = multi || (press_vld && !slot_free);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_code  <= '0;
         evt_valid <= 1'b0;
         evt_ovf   <= 1'b0;
      end else begin
         if (press_vld && slot_free) begin
            evt_code  <= press_code;
            evt_valid <= 1'b1;
         end else if (accept) begin
            evt_valid <= 1'b0;
         end
         if (drop)        evt_ovf <= 1'b1;
         else if (accept) evt_ovf <= 1'b0;
      end
   end
endmodule

// File: tb/tb_btn_cond.sv
// Scoreboard bench for btn_cond: expected events queued with their edge number
// at stimulus time, popped by a negedge monitor when an event is loaded.

module tb_btn_cond;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] btn_raw;
   logic [4:0] btn_lvl, evt_code;
   logic       evt_valid, evt_ack, evt_ovf;

   typedef struct {
      logic [4:0] code;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   logic pv = 1'b0, pa = 1'b0;

   btn_cond #(.N_BTN(5), .DB_CYCLES(16'd4), .REP_DELAY(20'd10), .REP_PERIOD(20'd3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_raw   (btn_raw),
      .btn_lvl   (btn_lvl),
      .evt_code  (evt_code),
      .evt_valid (evt_valid),
      .evt_ack   (evt_ack),
      .evt_ovf   (evt_ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cyc %0d: got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_evt(input logic [4:0] c, input int at);
      exp_t e;
      e.code = c;
      e.cyc  = at;
      exp_q.push_back(e);
   endtask

   // A load is visible when valid is high and either the slot was empty or
   // the previous event was acked at the edge just passed.
   always @(negedge clk) begin
      exp_t e;
      if (evt_valid && (!pv || pa)) begin
         chk("evt_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("evt_code", evt_code, e.code);
            chk("evt_cyc", cyc, e.cyc);
         end
      end
      pv <= evt_valid;
      pa <= evt_ack;
   end

   initial begin
      int c0, c1;
      rst_n   = 1'b0;
      btn_raw = 5'h1f;
      evt_ack = 1'b0;
      edges(3);
      chk("rst_lvl", btn_lvl, 0);
      chk("rst_valid", evt_valid, 0);
      chk("rst_code", evt_code, 0);
      chk("rst_ovf", evt_ovf, 0);

      // all five held through reset release
      rst_n = 1'b1;
      c0 = cyc;
      expect_evt(5'b00001, c0 + 7);
      for (int k = 1; k <= 7; k++) begin
         edges(1);
         chk("t1_lvl", btn_lvl, (k >= 6) ? 5'h1f : 5'h00);
         chk("t1_valid", evt_valid, (k >= 7) ? 1 : 0);
      end
      chk("t1_ovf", evt_ovf, 1);
      btn_raw = 5'h00;
      evt_ack = 1'b1;
      edges(1);
      evt_ack = 1'b0;
      chk("t1_ack_valid", evt_valid, 0);
      chk("t1_ack_ovf", evt_ovf, 0);
      edges(10);
      chk("t1_rel_lvl", btn_lvl, 0);

      // glitch of 3 cycles rejected, then a 10-cycle hold accepted
      btn_raw[2] = 1'b1;
      edges(3);
      btn_raw[2] = 1'b0;
      edges(10);
      chk("t2_glitch_lvl", btn_lvl, 0);
      c0 = cyc;
      expect_evt(5'b00100, c0 + 7);
      btn_raw[2] = 1'b1;
      edges(5);
      chk("t2_lvl_e5", btn_lvl[2], 0);
      edges(1);
      chk("t2_lvl_e6", btn_lvl[2], 1);
      edges(1);
      chk("t2_valid_e7", evt_valid, 1);
      edges(3);
      btn_raw[2] = 1'b0;
      evt_ack = 1'b1;
      edges(1);
      evt_ack = 1'b0;
      chk("t2_ack_valid", evt_valid, 0);
      edges(8);

      // handshake: event held 20 cycles without ack
      c0 = cyc;
      expect_evt(5'b00010, c0 + 7);
      btn_raw[1] = 1'b1;
      edges(8);
      btn_raw[1] = 1'b0;
      for (int k = 0; k < 20; k++) begin
         edges(1);
         chk("t3_hold_valid", evt_valid, 1);
         chk("t3_hold_code", evt_code, 5'b00010);
      end
      evt_ack = 1'b1;
      edges(1);
      evt_ack = 1'b0;
      chk("t3_ack_valid", evt_valid, 0);
      edges(2);

      // overflow: btn3 pressed while btn1 pending
      c0 = cyc;
      expect_evt(5'b00010, c0 + 7);
      btn_raw[1] = 1'b1;
      edges(8);
      btn_raw[1] = 1'b0;
      edges(8);
      btn_raw[3] = 1'b1;
      edges(7);
      chk("t4_code", evt_code, 5'b00010);
      chk("t4_ovf", evt_ovf, 1);
      chk("t4_valid", evt_valid, 1);
      edges(1);
      btn_raw[3] = 1'b0;
      evt_ack = 1'b1;
      edges(1);
      evt_ack = 1'b0;
      chk("t4_ack_valid", evt_valid, 0);
      chk("t4_ack_ovf", evt_ovf, 0);
      edges(8);

      // ack in the same cycle as a btn4 press
      c0 = cyc;
      expect_evt(5'b00010, c0 + 7);
      btn_raw[1] = 1'b1;
      edges(8);
      btn_raw[1] = 1'b0;
      edges(8);
      c1 = cyc;
      expect_evt(5'b10000, c1 + 7);
      btn_raw[4] = 1'b1;
      edges(6);
      evt_ack = 1'b1;
      edges(1);
      evt_ack = 1'b0;
      chk("t5_valid", evt_valid, 1);
      chk("t5_code", evt_code, 5'b10000);
      chk("t5_ovf", evt_ovf, 0);
      edges(1);
      btn_raw[4] = 1'b0;
      evt_ack = 1'b1;
      edges(1);
      evt_ack = 1'b0;
      chk("t5_ack_valid", evt_valid, 0);
      edges(8);

      // long hold of btn0 with ack tied high
      evt_ack = 1'b1;
      c0 = cyc;
      expect_evt(5'b00001, c0 + 7);
`ifdef BTN_REPEAT_EN
      for (int k = 0; k < 5; k++) expect_evt(5'b00001, c0 + 18 + 3 * k);
`endif
      btn_raw[0] = 1'b1;
      edges(25);
      btn_raw[0] = 1'b0;
      edges(20);
      evt_ack = 1'b0;
      chk("t6_ovf", evt_ovf, 0);
      chk("t6_lvl", btn_lvl, 0);

      // asynchronous reset with an event pending
      c0 = cyc;
      expect_evt(5'b00100, c0 + 7);
      btn_raw[2] = 1'b1;
      edges(8);
      btn_raw[2] = 1'b0;
      chk("t7_pending", evt_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t7_rst_valid", evt_valid, 0);
      chk("t7_rst_code", evt_code, 0);
      chk("t7_rst_lvl", btn_lvl, 0);
      edges(2);
      rst_n = 1'b1;
      edges(10);
      chk("t7_idle_valid", evt_valid, 0);

      chk("evt_q_left", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
